// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and helpers for the fifo write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Circular search begins just after the previous winner.
   function automatic int unsigned rr_start_idx(input int unsigned last_grant,
                                                input int unsigned num_req);
      return (last_grant + 1) % num_req;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker over a request vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_last_grant,
   output logic [ID_W-1:0]    o_grant_id,
   output logic               o_valid
);

   int unsigned     w_start;
   logic [ID_W-1:0] w_idx;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      o_grant_id = '0;
      o_valid    = 1'b0;
      w_idx      = '0;
      w_start    = rr_start_idx(32'(i_last_grant), NUM_REQ);
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_idx = ID_W'((w_start + 32'(i)) % NUM_REQ);
         if (i_req[w_idx]) begin
            o_grant_id = w_idx;
            o_valid    = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one fifo write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int BUS_WIDTH = 32,
   parameter  int MAX_BURST = 8,
   localparam int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           i_req,
   input  logic [NUM_REQ*BUS_WIDTH-1:0] i_data,
   output logic [NUM_REQ-1:0]           o_ack,
   output logic                         o_fifo_wr,
   output logic [BUS_WIDTH-1:0]         o_fifo_data,
   input  logic                         i_fifo_full,
   output logic [ID_W-1:0]              o_grant_id,
   output logic                         o_busy
);

   localparam int                 c_CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [ID_W-1:0]     r_grant_id;
   logic [ID_W-1:0]     r_last_grant;
   logic [c_CNT_W-1:0]  r_beat_cnt;
   logic [ID_W-1:0]     w_pick_id;
   logic                w_pick_valid;
   logic                w_req_g;
   logic                w_accept;
   logic                w_release;
   logic [BUS_WIDTH-1:0] w_slice [NUM_REQ];

   genvar k;
   generate
      for (k = 0; k < NUM_REQ; k++) begin : g_slice
         assign w_slice[k] = i_data[k*BUS_WIDTH +: BUS_WIDTH];
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .i_req        (i_req),
      .i_last_grant (r_last_grant),
      .o_grant_id   (w_pick_id),
      .o_valid      (w_pick_valid)
   );

   assign w_req_g    = i_req[r_grant_id];
   assign o_grant_id = r_grant_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      o_fifo_wr   = 1'b0;
      o_ack       = '0;
      o_fifo_data = '0;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            o_busy                = 1'b1;
            o_fifo_data           = w_slice[r_grant_id];
            w_accept              = w_req_g && !i_fifo_full;
            o_fifo_wr             = w_accept;
            o_ack[r_grant_id]     = w_accept;
            // A dropped request ends the burst without a write.
            w_release = !w_req_g || (w_accept && (r_beat_cnt == c_LAST_BEAT));
            if (w_release) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant_id   <= '0;
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_beat_cnt   <= '0;
      end else begin
         if ((r_state == IDLE) && w_pick_valid) begin
            r_grant_id <= w_pick_id;
         end
         if (w_release) begin
            r_last_grant <= r_grant_id;
            r_beat_cnt   <= '0;
         end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed bench for fifo_wr_arbiter (4x8 and 2x1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

   logic         clk;
   logic         rst_n;

   logic [3:0]   a_req;
   logic [127:0] a_data;
   logic [3:0]   a_ack;
   logic         a_wr;
   logic [31:0]  a_fdata;
   logic         a_full;
   logic [1:0]   a_grant;
   logic         a_busy;

   logic [1:0]   b_req;
   logic [63:0]  b_data;
   logic [1:0]   b_ack;
   logic         b_wr;
   logic [31:0]  b_fdata;
   logic         b_grant;
   logic         b_busy;

   int           vectors;
   int           miscompares;
   logic [31:0]  ncnt [4];

   fifo_wr_arbiter #(
      .NUM_REQ   (4),
      .BUS_WIDTH (32),
      .MAX_BURST (8)
   ) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (a_req),
      .i_data      (a_data),
      .o_ack       (a_ack),
      .o_fifo_wr   (a_wr),
      .o_fifo_data (a_fdata),
      .i_fifo_full (a_full),
      .o_grant_id  (a_grant),
      .o_busy      (a_busy)
   );

   fifo_wr_arbiter #(
      .NUM_REQ   (2),
      .BUS_WIDTH (32),
      .MAX_BURST (1)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (b_req),
      .i_data      (b_data),
      .o_ack       (b_ack),
      .o_fifo_wr   (b_wr),
      .o_fifo_data (b_fdata),
      .i_fifo_full (1'b0),
      .o_grant_id  (b_grant),
      .o_busy      (b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      a_req  = '0;
      b_req  = '0;
      a_full = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
   endtask

   task automatic drive_all();
      for (int k = 0; k < 4; k++) begin
         a_data[k*32 +: 32] = (32'(k) << 28) + ncnt[k];
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      a_req       = '0;
      a_data      = '0;
      a_full      = 1'b0;
      b_req       = '0;
      b_data      = '0;
      for (int k = 0; k < 4; k++) ncnt[k] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy",  64'(a_busy),  64'd0);
      chk("rst_wr",    64'(a_wr),    64'd0);
      chk("rst_ack",   64'(a_ack),   64'd0);
      chk("rst_grant", 64'(a_grant), 64'd0);
      chk("rst_data",  64'(a_fdata), 64'd0);
      chk("rst_b_busy", 64'(b_busy), 64'd0);

      // Single requester, full burst, bubble, re-grant
      @(negedge clk);
      rst_n = 1'b1;
      a_req = 4'b0001;
      #1;
      chk("t1_arb_latency", 64'(a_busy), 64'd0);
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         a_data[31:0] = 32'h0A00_0000 + 32'(b);
         #1;
         chk("t1_busy", 64'(a_busy),  64'd1);
         chk("t1_wr",   64'(a_wr),    64'd1);
         chk("t1_ack",  64'(a_ack),   64'd1);
         chk("t1_data", 64'(a_fdata), 64'h0A00_0000 + 64'(b));
      end
      @(negedge clk);
      #1;
      chk("t1_bubble_busy", 64'(a_busy), 64'd0);
      chk("t1_bubble_wr",   64'(a_wr),   64'd0);
      @(negedge clk);
      #1;
      chk("t1_regrant_busy",  64'(a_busy),  64'd1);
      chk("t1_regrant_grant", 64'(a_grant), 64'd0);
      chk("t1_regrant_ack",   64'(a_ack),   64'd1);
      @(negedge clk);
      a_req = 4'b0000;
      #1;
      chk("t1_drop_wr",  64'(a_wr),  64'd0);
      chk("t1_drop_ack", 64'(a_ack), 64'd0);
      @(negedge clk);
      #1;
      chk("t1_drop_idle", 64'(a_busy), 64'd0);

      // All four requesting: order 0,1,2,3,0 with 8 beats each
      do_reset();
      a_req = 4'b1111;
      drive_all();
      for (int gi = 0; gi < 5; gi++) begin
         for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            drive_all();
            #1;
            chk("t2_grant", 64'(a_grant), 64'(gi % 4));
            chk("t2_ack",   64'(a_ack),   64'd1 << (gi % 4));
            chk("t2_wr",    64'(a_wr),    64'd1);
            chk("t2_data",  64'(a_fdata), 64'((32'(gi % 4) << 28) + ncnt[gi % 4]));
            ncnt[gi % 4] = ncnt[gi % 4] + 32'd1;
         end
         @(negedge clk);
         drive_all();
         #1;
         chk("t2_bubble", 64'(a_busy), 64'd0);
      end

      // Requester 2 with fifo full for burst cycles 3..6
      do_reset();
      a_req = 4'b0100;
      begin
         logic [31:0] n;
         logic        f;
         n = '0;
         for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            f = (c >= 3) && (c <= 6);
            a_full = f;
            a_data[64 +: 32] = 32'h2222_0000 + n;
            #1;
            chk("t3_busy",  64'(a_busy),  64'd1);
            chk("t3_grant", 64'(a_grant), 64'd2);
            chk("t3_wr",    64'(a_wr),    f ? 64'd0 : 64'd1);
            chk("t3_ack",   64'(a_ack),   f ? 64'd0 : 64'd4);
            chk("t3_data",  64'(a_fdata), 64'(32'h2222_0000 + n));
            if (!f) n = n + 32'd1;
         end
      end
      @(negedge clk);
      a_full = 1'b0;
      #1;
      chk("t3_release", 64'(a_busy), 64'd0);

      // Requester 1 drops after 3 beats; next grant goes to 2, not 0
      do_reset();
      a_req = 4'b0010;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         #1;
         chk("t4_ack", 64'(a_ack), 64'd2);
      end
      @(negedge clk);
      a_req = 4'b0101;
      #1;
      chk("t4_drop_wr",   64'(a_wr),   64'd0);
      chk("t4_drop_ack",  64'(a_ack),  64'd0);
      chk("t4_drop_busy", 64'(a_busy), 64'd1);
      @(negedge clk);
      #1;
      chk("t4_bubble", 64'(a_busy), 64'd0);
      @(negedge clk);
      #1;
      chk("t4_next_grant", 64'(a_grant), 64'd2);
      chk("t4_next_ack",   64'(a_ack),   64'd4);

      // Reset mid-burst after beat 5 of requester 3
      do_reset();
      a_req = 4'b1000;
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         #1;
         chk("t5_grant", 64'(a_grant), 64'd3);
         chk("t5_ack",   64'(a_ack),   64'd8);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_wr",    64'(a_wr),    64'd0);
      chk("t5_rst_ack",   64'(a_ack),   64'd0);
      chk("t5_rst_busy",  64'(a_busy),  64'd0);
      chk("t5_rst_grant", 64'(a_grant), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      a_req = 4'b1001;
      #1;
      chk("t5_post_idle", 64'(a_busy), 64'd0);
      @(negedge clk);
      #1;
      chk("t5_post_grant", 64'(a_grant), 64'd0);
      chk("t5_post_ack",   64'(a_ack),   64'd1);

      // MAX_BURST=1, NUM_REQ=2: alternating single-beat grants with bubbles
      do_reset();
      a_req  = 4'b0000;
      b_req  = 2'b11;
      b_data = {32'hBBBB_0001, 32'hAAAA_0000};
      #1;
      chk("t6_arb_latency", 64'(b_busy), 64'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         if ((i % 2) == 0) begin
            chk("t6_busy",  64'(b_busy),  64'd1);
            chk("t6_grant", 64'(b_grant), 64'((i / 2) % 2));
            chk("t6_ack",   64'(b_ack),   64'd1 << ((i / 2) % 2));
            chk("t6_wr",    64'(b_wr),    64'd1);
            chk("t6_data",  64'(b_fdata), (((i / 2) % 2) == 0) ? 64'hAAAA_0000 : 64'hBBBB_0001);
         end else begin
            chk("t6_bubble_busy", 64'(b_busy), 64'd0);
            chk("t6_bubble_wr",   64'(b_wr),   64'd0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
